// File: rtl/mul_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and
// default sizes.
package mul_arbiter_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_core.sv
// Iterative shift-add multiplier, one partial product per cycle.
// product is the next accumulator value; it is the full product while done.
module mul_seq_core
  import mul_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] ma;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mb;
  logic [CW-1:0]      cnt;
  logic               run;

  assign product = acc + (mb[0] ? ma : '0);
  assign busy    = run;
  assign done    = run && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      ma  <= '0;
      mb  <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      ma  <= {{WIDTH{1'b0}}, a};
      mb  <= b;
      acc <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      acc <= product;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between requesters.
// Define MUL_ARB_HIGH_EN to add the result_hi and ovf outputs.
module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
`ifdef MUL_ARB_HIGH_EN
  output logic [WIDTH-1:0]         result_hi,
  output logic                     ovf,
`endif
  output logic                     busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t             state;
  state_t             state_nxt;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      pick;
  logic               found;
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               core_busy;
  logic               core_done;
  logic [2*WIDTH-1:0] product;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign op_a = a_in[pick*WIDTH +: WIDTH];
  assign op_b = b_in[pick*WIDTH +: WIDTH];

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt = ST_RUN;
          start     = 1'b1;
        end
      end
      ST_RUN:  if (core_done) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      result    <= '0;
`ifdef MUL_ARB_HIGH_EN
      result_hi <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (start) begin
        owner <= pick;
        ptr   <= (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
      end
      // Final step of the core: capture so result is visible in DONE.
      if (state == ST_RUN && core_done) begin
        result    <= product[WIDTH-1:0];
`ifdef MUL_ARB_HIGH_EN
        result_hi <= product[2*WIDTH-1:WIDTH];
`endif
      end
    end
  end

  assign busy  = (state != ST_IDLE);
  assign grant = busy ? (ONE << owner) : '0;
  assign done  = (state == ST_DONE) ? grant : '0;

`ifdef MUL_ARB_HIGH_EN
  assign ovf = |result_hi;

  logic unused_core;
  assign unused_core = core_busy;
`else
  logic unused_core;
  assign unused_core = ^{core_busy, product[2*WIDTH-1:WIDTH]};
`endif

  mul_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (op_a),
    .b      (op_b),
    .busy   (core_busy),
    .done   (core_done),
    .product(product)
  );

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter (4 requesters, 8-bit).
// Define MUL_ARB_HIGH_EN to also check result_hi and ovf.
module tb_mul_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic [W-1:0] result;
  logic         busy;
`ifdef MUL_ARB_HIGH_EN
  logic [W-1:0] result_hi;
  logic         ovf;
`endif

  int n_tests;
  int n_fail;

  mul_arbiter #(
    .NUM_REQ(N),
    .WIDTH  (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .grant    (grant),
    .done     (done),
    .result   (result),
`ifdef MUL_ARB_HIGH_EN
    .result_hi(result_hi),
    .ovf      (ovf),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a done pulse, then check owner, latency and result.
  task automatic txn(input int who, input int exp_res, input int exp_cyc);
    int cyc;
    logic [N-1:0] oh;
    oh  = 4'b0001 << who;
    cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (done != '0) break;
    end
    check("done_owner", 32'(done), 32'(oh));
    check("latency", 32'(cyc), 32'(exp_cyc));
    check("result", 32'(result), 32'(exp_res));
    check("grant_in_done", 32'(grant), 32'(oh));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    req     = '0;
    a_in    = '0;
    b_in    = '0;

    // reset state
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: single request
    req = 4'b0001;
    set_op(0, 5, 7);
    tick();
    check("t1_grant", 32'(grant), 32'b0001);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_nodone", 32'(done), 32'd0);
    txn(0, 35, 8);
`ifdef MUL_ARB_HIGH_EN
    check("t1_ovf", 32'(ovf), 32'd0);
`endif
    req = '0;
    tick();
    check("t1_done_gone", 32'(done), 32'd0);
    check("t1_grant_gone", 32'(grant), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_held", 32'(result), 32'd35);

    // 2: truncation, 200*3 = 600 = 0x258
    req = 4'b0001;
    set_op(0, 200, 3);
    txn(0, 88, 9);
`ifdef MUL_ARB_HIGH_EN
    check("t2_hi", 32'(result_hi), 32'd2);
    check("t2_ovf", 32'(ovf), 32'd1);
`endif
    req = '0;
    do_reset();

    // 3: contention, round robin 0,1,2,3,0
    set_op(0, 3, 4);
    set_op(1, 15, 17);
    set_op(2, 16, 16);
    set_op(3, 255, 255);
    req = 4'b1111;
    txn(0, 12, 9);
    txn(1, 255, 10);
    txn(2, 0, 10);
    txn(3, 1, 10);
    txn(0, 12, 10);
    req = '0;
    do_reset();

    // 4: fairness between 0 and 2, a=0 gives 0
    set_op(0, 9, 9);
    set_op(2, 0, 77);
    req = 4'b0101;
    txn(0, 81, 9);
    txn(2, 0, 10);
    txn(0, 81, 10);
    txn(2, 0, 10);
    req = '0;
    tick();

    // 5: req dropped mid-run, operands changed after latch
    req = 4'b0010;
    set_op(1, 12, 11);
    tick();
    check("t5_grant", 32'(grant), 32'b0010);
    tick();
    tick();
    tick();
    req = '0;
    set_op(1, 99, 99);
    txn(1, 132, 5);
    tick();

    // 6: reset in RUN cycle 4 aborts
    req = 4'b1000;
    set_op(3, 10, 10);
    tick();
    check("t6_grant", 32'(grant), 32'b1000);
    repeat (3) tick();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
    check("t6_grant0", 32'(grant), 32'd0);
    check("t6_busy0", 32'(busy), 32'd0);
    check("t6_result0", 32'(result), 32'd0);
    check("t6_done0", 32'(done), 32'd0);
    cnt = 0;
    repeat (12) begin
      tick();
      if (done != '0) cnt++;
    end
    check("t6_no_done", 32'(cnt), 32'd0);
    set_op(0, 2, 3);
    set_op(1, 1, 1);
    set_op(2, 1, 1);
    set_op(3, 1, 1);
    req = 4'b1111;
    txn(0, 6, 9);
    req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
